// File: rtl/sc_branch_eval.sv
// Bicc branch condition evaluator fed by the PSR {N,Z,V,C} flags.
// Waits out in-flight PSR writes, then returns a registered taken/annul decision.
module sc_branch_eval #(
  parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
  parameter int unsigned DATAWIDTH_COND          = 4,
  parameter int unsigned DATAWIDTH_COUNT         = 8
) (
  input  logic                               SC_BranchEval_CLOCK_50,
  input  logic                               SC_BranchEval_RESET_InLow,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] SC_BranchEval_Flags,
  input  logic                               SC_BranchEval_PsrWrite_InLow,
  input  logic                               SC_BranchEval_ReqValid,
  input  logic [DATAWIDTH_COND-1:0]          SC_BranchEval_Cond,
  input  logic                               SC_BranchEval_Annul,
  output logic                               SC_BranchEval_ReqReady,
  output logic                               SC_BranchEval_ResValid,
  output logic                               SC_BranchEval_Taken,
  output logic                               SC_BranchEval_AnnulSlot,
  output logic                               SC_BranchEval_Busy,
  output logic [DATAWIDTH_COUNT-1:0]         SC_BranchEval_TakenCount
);

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;
  localparam logic [DATAWIDTH_COND-1:0]  COND_ALWAYS = DATAWIDTH_COND'(8);
  localparam logic [DATAWIDTH_COUNT-1:0] COUNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [DATAWIDTH_COND-1:0] cond_q;
  logic                      annul_q;
  logic                      flag_n;
  logic                      flag_z;
  logic                      flag_v;
  logic                      flag_c;
  logic                      base_c;
  logic                      taken_c;
  logic                      annul_slot_c;

  assign flag_n = SC_BranchEval_Flags[FLAG_N];
  assign flag_z = SC_BranchEval_Flags[FLAG_Z];
  assign flag_v = SC_BranchEval_Flags[FLAG_V];
  assign flag_c = SC_BranchEval_Flags[FLAG_C];

  // Upper cond bit inverts the base predicate selected by the lower three bits.
  always_comb begin
    base_c = 1'b0;
    unique case (cond_q[2:0])
      3'd0: base_c = 1'b0;
      3'd1: base_c = flag_z;
      3'd2: base_c = flag_z | (flag_n ^ flag_v);
      3'd3: base_c = flag_n ^ flag_v;
      3'd4: base_c = flag_c | flag_z;
      3'd5: base_c = flag_c;
      3'd6: base_c = flag_n;
      3'd7: base_c = flag_v;
      default: base_c = 1'b0;
    endcase
    taken_c      = base_c ^ cond_q[3];
    annul_slot_c = annul_q & ((cond_q == COND_ALWAYS) | ~taken_c);
  end

  // Next-state logic; EVAL holds while a PSR write is pending.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (SC_BranchEval_ReqValid) state_next = EVAL;
      EVAL: if (SC_BranchEval_PsrWrite_InLow) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge SC_BranchEval_CLOCK_50 or negedge SC_BranchEval_RESET_InLow) begin
    if (!SC_BranchEval_RESET_InLow) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge SC_BranchEval_CLOCK_50 or negedge SC_BranchEval_RESET_InLow) begin
    if (!SC_BranchEval_RESET_InLow) begin
      cond_q                   <= '0;
      annul_q                  <= 1'b0;
      SC_BranchEval_Taken      <= 1'b0;
      SC_BranchEval_AnnulSlot  <= 1'b0;
      SC_BranchEval_ResValid   <= 1'b0;
      SC_BranchEval_TakenCount <= '0;
    end else begin
      SC_BranchEval_ResValid <= (state == RESP);
      if (state == IDLE && SC_BranchEval_ReqValid) begin
        cond_q  <= SC_BranchEval_Cond;
        annul_q <= SC_BranchEval_Annul;
      end
      if (state == EVAL && SC_BranchEval_PsrWrite_InLow) begin
        SC_BranchEval_Taken     <= taken_c;
        SC_BranchEval_AnnulSlot <= annul_slot_c;
        if (taken_c && SC_BranchEval_TakenCount != COUNT_MAX) begin
          SC_BranchEval_TakenCount <= SC_BranchEval_TakenCount + DATAWIDTH_COUNT'(1);
        end
      end
    end
  end

  assign SC_BranchEval_ReqReady = (state == IDLE);
  assign SC_BranchEval_Busy     = (state != IDLE);

endmodule

// File: tb/tb_sc_branch_eval.sv
// Scoreboard bench for sc_branch_eval: randomized Bicc requests against a
// condition-table model, plus stall, annul, mid-operation reset and saturation cases.
module tb_sc_branch_eval;

  logic       clk;
  logic       rst_n;
  logic [3:0] flags;
  logic       psr_w_n;
  logic       req_valid;
  logic [3:0] cond;
  logic       annul;
  logic       req_ready;
  logic       res_valid;
  logic       taken;
  logic       annul_slot;
  logic       busy;
  logic [7:0] taken_count;

  sc_branch_eval dut (
    .SC_BranchEval_CLOCK_50      (clk),
    .SC_BranchEval_RESET_InLow   (rst_n),
    .SC_BranchEval_Flags         (flags),
    .SC_BranchEval_PsrWrite_InLow(psr_w_n),
    .SC_BranchEval_ReqValid      (req_valid),
    .SC_BranchEval_Cond          (cond),
    .SC_BranchEval_Annul         (annul),
    .SC_BranchEval_ReqReady      (req_ready),
    .SC_BranchEval_ResValid      (res_valid),
    .SC_BranchEval_Taken         (taken),
    .SC_BranchEval_AnnulSlot     (annul_slot),
    .SC_BranchEval_Busy          (busy),
    .SC_BranchEval_TakenCount    (taken_count)
  );

  typedef struct {
    bit taken;
    bit annul;
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bicc condition table, {N,Z,V,C}.
  function automatic bit ref_taken(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'd0:  return 1'b0;
      4'd1:  return z;
      4'd2:  return z || (n != v);
      4'd3:  return n != v;
      4'd4:  return cy || z;
      4'd5:  return cy;
      4'd6:  return n;
      4'd7:  return v;
      4'd8:  return 1'b1;
      4'd9:  return !z;
      4'd10: return !(z || (n != v));
      4'd11: return n == v;
      4'd12: return !(cy || z);
      4'd13: return !cy;
      4'd14: return !n;
      default: return !v;
    endcase
  endfunction

  // Monitor: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("taken", int'(taken), int'(e.taken));
        chk("annul_slot", int'(annul_slot), int'(e.annul));
        chk("res_latency_cycle", cyc, e.cyc);
        chk("taken_count", int'(taken_count), e.cnt);
      end
    end
  end

  task automatic do_req(input logic [3:0] c, input bit a, input logic [3:0] f0,
                        input int stalls, input logic [3:0] f1, input bit probe);
    exp_t e;
    int   k;
    @(negedge clk);
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    chk("req_ready_before_req", int'(req_ready), 1);
    flags     = (stalls == 0) ? f1 : f0;
    cond      = c;
    annul     = a;
    req_valid = 1'b1;
    psr_w_n   = (stalls == 0);
    @(posedge clk); #1;
    k         = cyc;
    req_valid = 1'b0;
    cond      = 4'($urandom);
    annul     = 1'($urandom);
    for (int i = 0; i < stalls; i++) begin
      @(posedge clk); #1;
      flags = f1;
      if (i == stalls - 1) psr_w_n = 1'b1;
    end
    e.taken = ref_taken(c, f1);
    e.annul = a && ((c == 4'd8) || !e.taken);
    if (e.taken) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    e.cnt = exp_cnt;
    e.cyc = k + 2 + stalls;
    sb.push_back(e);
    @(posedge clk); #1;
    if (probe) begin
      chk("req_ready_in_resp", int'(req_ready), 0);
      chk("busy_in_resp", int'(busy), 1);
      req_valid = 1'b1;
    end
    @(posedge clk); #1;
    if (probe) begin
      chk("no_accept_in_resp", int'(busy), 0);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flags = '0; psr_w_n = 1'b1; req_valid = 1'b0; cond = '0; annul = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_taken", int'(taken), 0);
    chk("reset_annul_slot", int'(annul_slot), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_state", int'({req_ready, busy, res_valid}), 3'b100);
      chk("idle_count", int'(taken_count), 0);
    end

    // Full decode sweep.
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++)
        do_req(4'(c), 1'($urandom), 4'(f), 0, 4'(f), 1'b0);

    // Stall while the PSR write lands: Z=1 before, Z=0 after.
    do_req(4'd1, 1'b0, 4'b0100, 3, 4'b0000, 1'b0);

    // Annul rule.
    do_req(4'd8, 1'b1, 4'($urandom), 0, 4'b0000, 1'b0);
    do_req(4'd1, 1'b1, 4'b0000, 0, 4'b0000, 1'b0);
    do_req(4'd1, 1'b1, 4'b0100, 0, 4'b0100, 1'b0);

    // Random mix with random stalls.
    for (int i = 0; i < 40; i++)
      do_req(4'($urandom), 1'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
             4'($urandom), 1'($urandom_range(0, 3) == 0));

    // Reset during EVAL aborts the request.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    flags = 4'b1111; cond = 4'd8; annul = 1'b1; req_valid = 1'b1; psr_w_n = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_in_eval", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_ready", int'(req_ready), 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_count", int'(taken_count), 0);
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    psr_w_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_ready", int'(req_ready), 1);
    do_req(4'd9, 1'b0, 4'b0000, 0, 4'b0000, 1'b0);

    // Counter saturation.
    for (int i = 0; i < 260; i++)
      do_req(4'd8, 1'($urandom), 4'($urandom), 0, 4'($urandom), i == 259);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    chk("count_saturated", int'(taken_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_branch_eval.md
Name: sc_branch_eval

Overview:
- Consumer side of the processor status register (PSR) flag interface.
- Reads the registered {N,Z,V,C} flag vector and the PSR's active-low write strobe.
- Evaluates the 16 SPARC Bicc condition codes and returns a registered taken/annul decision to the control unit through a valid/ready handshake.
- Stalls evaluation while a PSR write is in flight, so a decision never uses stale flags. Keeps a saturating taken-branch counter for debug.

Parameters:
- DATAWIDTH_ALU_SELECTION, 4, flag vector width, ordered {N,Z,V,C} MSB..LSB.
- DATAWIDTH_COND, 4, condition field width.
- DATAWIDTH_COUNT, 8, taken-branch counter width.

Ports:
- SC_BranchEval_CLOCK_50  in  1  system clock, rising edge.
- SC_BranchEval_RESET_InLow  in  1  asynchronous active-low reset.
- SC_BranchEval_Flags  in  DATAWIDTH_ALU_SELECTION  PSR output {N,Z,V,C}.
- SC_BranchEval_PsrWrite_InLow  in  1  PSR write strobe, low = flags update at next edge.
- SC_BranchEval_ReqValid  in  1  request strobe.
- SC_BranchEval_Cond  in  DATAWIDTH_COND  Bicc cond field.
- SC_BranchEval_Annul  in  1  Bicc 'a' bit.
- SC_BranchEval_ReqReady  out  1  high when a request can be accepted.
- SC_BranchEval_ResValid  out  1  one-cycle result strobe.
- SC_BranchEval_Taken  out  1  branch taken.
- SC_BranchEval_AnnulSlot  out  1  annul the delay-slot instruction.
- SC_BranchEval_Busy  out  1  high in any state other than IDLE.
- SC_BranchEval_TakenCount  out  DATAWIDTH_COUNT  saturating count of taken results.

Behaviour:
- Reset (asynchronous, low):
  - state = IDLE; cond/annul latches = 0.
  - Taken = 0, AnnulSlot = 0, ResValid = 0, TakenCount = 0.
  - ReqReady = 1, Busy = 0 (both decoded from state).
  - Reset asserted mid-operation aborts the request; no ResValid is produced.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - ReqReady = 1.
  - On an edge with ReqValid = 1: latch Cond and Annul, go to EVAL.
  - ReqValid is ignored in EVAL and RESP; no queuing.
- EVAL:
  - PsrWrite_InLow = 0 this cycle: stay in EVAL (stall). No cycle limit; Flags are re-sampled next cycle.
  - PsrWrite_InLow = 1: compute the condition from the current Flags, register Taken and AnnulSlot, go to RESP.
- RESP:
  - ResValid = 1 for exactly one cycle; Taken and AnnulSlot are valid.
  - Next state is IDLE.
  - Taken and AnnulSlot hold their value until the next RESP.
- Latency: request accepted at edge k → ResValid high between edges k+2 and k+3, plus one cycle per stall cycle. Throughput: one request per 3 cycles minimum.
- Condition decode (cond → taken):
  - 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V.
  - 0100 C|Z; 0101 C; 0110 N; 0111 V.
  - 1000 always; 1001 ~Z; 1010 ~(Z|(N^V)); 1011 ~(N^V).
  - 1100 ~(C|Z); 1101 ~C; 1110 ~N; 1111 ~V.
- Annul rule:
  - cond = 1000 (always) and a = 1 → AnnulSlot = 1.
  - Otherwise AnnulSlot = a & ~Taken.
  - a = 0 → AnnulSlot = 0.
- Counter:
  - Increments on the EVAL→RESP edge when the computed Taken = 1.
  - Saturates at all-ones; never wraps.
- Cond or Annul input changes after acceptance have no effect.

Test Plan:
- Reset then idle: release reset, no requests → ReqReady=1, Busy=0, ResValid=0, TakenCount=0 for 10 cycles.
- Full decode sweep: for each Flags value 0000..1111 and each cond 0..15, request with PsrWrite_InLow=1.
  - Taken must match the decode table.
  - ResValid is high exactly 2 cycles after acceptance.
- Stall: Flags=0100 (Z=1), request cond=0001; hold PsrWrite_InLow=0 for 3 EVAL cycles while Flags changes to 0000.
  - ResValid arrives at acceptance+5; Taken=0, using post-write flags.
- Annul: request cond=1000, a=1 → Taken=1, AnnulSlot=1. Request cond=0001, a=1, Z=0 → Taken=0, AnnulSlot=1. Request cond=0001, a=1, Z=1 → Taken=1, AnnulSlot=0.
- Reset mid-operation: accept a request, assert reset during EVAL → no ResValid. After release: ReqReady=1, TakenCount=0, next request completes normally.
- Counter saturation: issue 260 requests with cond=1000 → TakenCount=255 and stays 255. A ReqValid asserted during RESP is not accepted (ReqReady=0).
